lockstep_sync: RTL and testbench

//  Lockstep tick synchroniser between game logic and the UART link stage (communicate).
//  On each local game tick it latches the local direction and pulses send. It then waits
//  for the peer's direction (dir/rcvdir from the link stage) before issuing one tick_go,
//  so both boards advance the snakes in the same step. Handles timeout/retry and a fatal

---
 rtl/lockstep_sync.sv | 181 ++++++++++++++++++
 tb/tb_lockstep_sync.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/lockstep_sync.sv
// Lockstep tick synchroniser: exchanges one direction per game tick with the peer
// board over the link stage. Optional statistics counters are enabled by LOCKSTEP_STATS_EN.
package snake_pkg;
    typedef enum logic [2:0] {
        NONE  = 3'd0,
        UP    = 3'd1,
        DOWN  = 3'd2,
        LEFT  = 3'd3,
        RIGHT = 3'd4
    } direction;
endpackage

module lockstep_sync
    import snake_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 650_000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_req,
    input  direction   dir_local,
    output direction   dir_tx,
    output logic       send,
    input  direction   dir_rx,
    input  logic       rcvdir,
    output logic       tick_go,
    output direction   dir_remote,
    output logic       busy,
    output logic       link_err,
    output logic       overrun
`ifdef LOCKSTEP_STATS_EN
    ,
    output logic [15:0] retry_cnt,
    output logic [15:0] tick_cnt
`endif
);

    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEND  = 3'd1,
        S_WAIT  = 3'd2,
        S_GO    = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t          state_r, state_s;
    logic [TW-1:0]   timer_r;
    logic [RW-1:0]   retries_r;
    logic            pend_valid_r;
    direction        pend_dir_r;
    direction        dir_tx_r, dir_remote_r;
    logic            send_r, tick_go_r, busy_r, link_err_r, overrun_r;
    logic            take_s, resend_s, timer_end_s;

    // Next-state decode and the two WAIT exits that also update counters
    always_comb begin
        state_s     = state_r;
        take_s      = 1'b0;
        resend_s    = 1'b0;
        timer_end_s = (timer_r == TIMER_LAST);
        case (state_r)
            S_IDLE: begin
                if (tick_req) begin
                    state_s = S_SEND;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_SEND: state_s = S_WAIT;
            S_WAIT: begin
                if (pend_valid_r || rcvdir) begin
                    take_s  = 1'b1;
                    state_s = S_GO;
                end else if (timer_end_s) begin
                    if (retries_r < RETRY_MAX) begin
                        resend_s = 1'b1;
                        state_s  = S_SEND;
                    end else begin
                        state_s  = S_ERROR;
                    end
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_GO:    state_s = S_IDLE;
            S_ERROR: state_s = S_ERROR;
            default: state_s = S_IDLE;
        endcase
    end

    // State, timer, retry count and the registered outputs derived from next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            timer_r    <= '0;
            retries_r  <= '0;
            dir_tx_r   <= NONE;
            send_r     <= 1'b0;
            tick_go_r  <= 1'b0;
            busy_r     <= 1'b0;
            link_err_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            send_r     <= (state_s == S_SEND);
            tick_go_r  <= (state_s == S_GO);
            busy_r     <= (state_s != S_IDLE);
            link_err_r <= (state_s == S_ERROR);
            if (state_r == S_IDLE && tick_req) begin
                dir_tx_r  <= dir_local;
                retries_r <= '0;
            end else if (resend_s) begin
                retries_r <= retries_r + RW'(1);
            end
            if (state_r == S_SEND) begin
                timer_r <= '0;
            end else if (state_r == S_WAIT && state_s == S_WAIT) begin
                timer_r <= timer_r + TW'(1);
            end
        end
    end

    // One-entry pending buffer; a direction taken straight out of WAIT is consumed, not stored
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid_r <= 1'b0;
            pend_dir_r   <= NONE;
            dir_remote_r <= NONE;
            overrun_r    <= 1'b0;
        end else begin
            if (rcvdir && pend_valid_r && state_r != S_ERROR) begin
                overrun_r <= 1'b1;
            end
            if (take_s) begin
                pend_valid_r <= 1'b0;
                dir_remote_r <= rcvdir ? dir_rx : pend_dir_r;
            end else if (rcvdir && state_r != S_ERROR) begin
                pend_valid_r <= 1'b1;
                pend_dir_r   <= dir_rx;
            end
        end
    end

`ifdef LOCKSTEP_STATS_EN
    logic [15:0] retry_cnt_r, tick_cnt_r;

    // Resends saturate, ticks wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            retry_cnt_r <= 16'd0;
            tick_cnt_r  <= 16'd0;
        end else begin
            if (resend_s && retry_cnt_r != 16'hFFFF) begin
                retry_cnt_r <= retry_cnt_r + 16'd1;
            end
            if (take_s) begin
                tick_cnt_r <= tick_cnt_r + 16'd1;
            end
        end
    end

    assign retry_cnt = retry_cnt_r;
    assign tick_cnt  = tick_cnt_r;
`else
    // Statistics hardware is absent in this build.
`endif

    assign dir_tx     = dir_tx_r;
    assign send       = send_r;
    assign tick_go    = tick_go_r;
    assign dir_remote = dir_remote_r;
    assign busy       = busy_r;
    assign link_err   = link_err_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_lockstep_sync.sv
// Directed bench for lockstep_sync with TIMEOUT_CYCLES=16, MAX_RETRIES=2.
module tb_lockstep_sync;
    import snake_pkg::*;

    logic     clk = 1'b0;
    logic     rst, tick_req, rcvdir, send, tick_go, busy, link_err, overrun;
    direction dir_local, dir_tx, dir_rx, dir_remote;
`ifdef LOCKSTEP_STATS_EN
    logic [15:0] retry_cnt, tick_cnt;
`endif
    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    lockstep_sync #(.TIMEOUT_CYCLES(16), .MAX_RETRIES(2)) dut (
        .clk(clk), .rst(rst), .tick_req(tick_req), .dir_local(dir_local),
        .dir_tx(dir_tx), .send(send), .dir_rx(dir_rx), .rcvdir(rcvdir),
        .tick_go(tick_go), .dir_remote(dir_remote), .busy(busy),
        .link_err(link_err), .overrun(overrun)
`ifdef LOCKSTEP_STATS_EN
        , .retry_cnt(retry_cnt), .tick_cnt(tick_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Steps n cycles with idle inputs and counts send / tick_go pulses seen.
    task automatic idle_run(input int n, output int sends, output int gos);
        sends = 0;
        gos   = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (send) sends++;
            if (tick_go) gos++;
        end
    endtask

    initial begin
        int s, g, t0, first_err;
        int send_at[$];
        rst = 1'b1; tick_req = 1'b0; rcvdir = 1'b0;
        dir_local = NONE; dir_rx = NONE;
        do_reset();

        check_val("rst_dir_tx", int'(dir_tx), int'(NONE));
        check_val("rst_dir_remote", int'(dir_remote), int'(NONE));
        check_val("rst_outs", {send, tick_go, busy, link_err, overrun}, 0);

        // 1: peer direction already pending
        rcvdir = 1'b1; dir_rx = UP;
        step();
        rcvdir = 1'b0; dir_rx = NONE;
        tick_req = 1'b1; dir_local = LEFT;
        step();
        tick_req = 1'b0; dir_local = NONE;
        check_val("t1_send", send, 1);
        check_val("t1_dir_tx", int'(dir_tx), int'(LEFT));
        check_val("t1_busy", busy, 1);
        step();
        check_val("t1_go_early", tick_go, 0);
        check_val("t1_send_low", send, 0);
        step();
        check_val("t1_go", tick_go, 1);
        check_val("t1_dir_remote", int'(dir_remote), int'(UP));
        step();
        check_val("t1_go_pulse", tick_go, 0);
        check_val("t1_idle", busy, 0);

        // 2: local first, peer answers 10 cycles after send
        tick_req = 1'b1; dir_local = RIGHT;
        step();
        tick_req = 1'b0;
        check_val("t2_send", send, 1);
        idle_run(10, s, g);
        check_val("t2_wait_sends", s, 0);
        check_val("t2_wait_gos", g, 0);
        rcvdir = 1'b1; dir_rx = DOWN;
        step();
        rcvdir = 1'b0; dir_rx = NONE;
        check_val("t2_go", tick_go, 1);
        check_val("t2_dir_remote", int'(dir_remote), int'(DOWN));
        idle_run(40, s, g);
        check_val("t2_no_resend", s, 0);
        check_val("t2_single_go", g, 0);

        // 3: no peer, two resends then link error
        tick_req = 1'b1; dir_local = UP;
        step();
        tick_req = 1'b0;
        t0 = cyc;
        check_val("t3_send0", send, 1);
        first_err = -1;
        g = 0;
        for (int i = 0; i < 70; i++) begin
            step();
            if (send) send_at.push_back(cyc - t0);
            if (tick_go) g++;
            if (link_err && first_err < 0) first_err = cyc - t0;
        end
        check_val("t3_resend_cnt", send_at.size(), 2);
        if (send_at.size() == 2) begin
            check_val("t3_resend1_at", send_at[0], 17);
            check_val("t3_resend2_at", send_at[1], 34);
        end
        check_val("t3_err_at", first_err, 51);
        check_val("t3_no_go", g, 0);
        check_val("t3_dir_tx_kept", int'(dir_tx), int'(UP));
        do_reset();
        check_val("t3_rst_err", link_err, 0);
        check_val("t3_rst_busy", busy, 0);

        // 4: overrun, newest direction wins, tick_req during WAIT dropped
        rcvdir = 1'b1; dir_rx = UP;
        step();
        dir_rx = DOWN;
        step();
        rcvdir = 1'b0; dir_rx = NONE;
        check_val("t4_overrun", overrun, 1);
        tick_req = 1'b1; dir_local = LEFT;
        step();
        tick_req = 1'b0;
        step();
        tick_req = 1'b1;
        step();
        tick_req = 1'b0;
        check_val("t4_go", tick_go, 1);
        check_val("t4_dir_remote", int'(dir_remote), int'(DOWN));
        idle_run(40, s, g);
        check_val("t4_dropped_sends", s, 0);
        check_val("t4_dropped_gos", g, 0);
        check_val("t4_overrun_sticky", overrun, 1);

        // 5: reset in the middle of WAIT
        do_reset();
        tick_req = 1'b1; dir_local = RIGHT;
        step();
        tick_req = 1'b0;
        idle_run(5, s, g);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("t5_busy", busy, 0);
        check_val("t5_go", tick_go, 0);
        check_val("t5_dir_remote", int'(dir_remote), int'(NONE));
        check_val("t5_overrun", overrun, 0);
        rcvdir = 1'b1; dir_rx = LEFT;
        step();
        rcvdir = 1'b0;
        idle_run(30, s, g);
        check_val("t5_no_go_after", g, 0);

`ifdef LOCKSTEP_STATS_EN
        // 6: two resends then a late peer answer
        do_reset();
        check_val("t6_rst_retry", retry_cnt, 0);
        tick_req = 1'b1; dir_local = UP;
        step();
        tick_req = 1'b0;
        idle_run(37, s, g);
        check_val("t6_resends", s, 2);
        rcvdir = 1'b1; dir_rx = RIGHT;
        step();
        rcvdir = 1'b0;
        check_val("t6_go", tick_go, 1);
        check_val("t6_retry_cnt", retry_cnt, 2);
        check_val("t6_tick_cnt", tick_cnt, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
